cordic_cos_pipe: RTL and testbench

//  Parametrised, streaming CORDIC cosine unit with float32 in and float32 out.

---
 rtl/cordic_pkg.sv | 87 ++++++++
 rtl/cordic_iter.sv | 40 ++++
 rtl/cordic_cos_pipe.sv | 163 ++++++++++++++++
 tb/tb_cordic_cos_pipe.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_pkg
//  Description : Shared constants, types and float32 <-> fixed-point helpers
//                for the streaming CORDIC cosine unit.
//                ATAN_TABLE and CORDIC_K are Q2.30; narrower datapaths take
//                the top DATA_W bits.
//  Revision    : 1.0 - initial release
// ============================================================================
package cordic_pkg;

    // atan(2^-i) in Q2.30, truncated.
    localparam logic [31:0] ATAN_TABLE [0:31] = '{
        32'h3243F6A8, 32'h1DAC6705, 32'h0FADBAFC, 32'h07F56EA6,
        32'h03FEAB76, 32'h01FFD55B, 32'h00FFFAAA, 32'h007FFF55,
        32'h003FFFEA, 32'h001FFFFD, 32'h000FFFFF, 32'h0007FFFF,
        32'h0003FFFF, 32'h0001FFFF, 32'h0000FFFF, 32'h00007FFF,
        32'h00003FFF, 32'h00001FFF, 32'h00000FFF, 32'h000007FF,
        32'h000003FF, 32'h000001FF, 32'h000000FF, 32'h0000007F,
        32'h0000003F, 32'h0000001F, 32'h0000000F, 32'h00000007,
        32'h00000003, 32'h00000001, 32'h00000000, 32'h00000000
    };

    // CORDIC gain compensation 0.6072529350 in Q2.30.
    localparam logic [31:0] CORDIC_K = 32'h26DD3B6A;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } float32_t;

    // Angle needs clamping: |x| > 1.0, Inf or NaN (exp > 127 covers exp==255).
    function automatic logic f32_out_of_range(input logic [31:0] f);
        float32_t fv;
        fv = f;
        return (fv.exp > 8'd127) || ((fv.exp == 8'd127) && (fv.mant != 23'd0));
    endfunction

    // float32 -> two's complement Q2.frac_w, right-aligned in 32 bits.
    // Magnitude is truncated before the sign is applied so that negative
    // values also round toward zero.
    function automatic logic [31:0] f32_to_fix(input logic [31:0] f, input int frac_w);
        float32_t    fv;
        logic [31:0] mag;
        logic        neg;
        fv  = f;
        neg = fv.sign;
        mag = 32'd0;
        if (fv.exp == 8'd0) begin
            mag = 32'd0;
        end else if (f32_out_of_range(f)) begin
            mag = 32'h4000_0000;
            if ((fv.exp == 8'hFF) && (fv.mant != 23'd0)) begin
                neg = 1'b0;
            end
        end else begin
            mag = {2'b01, fv.mant, 7'b0} >> (8'd127 - fv.exp);
        end
        mag = mag >> (30 - frac_w);
        return neg ? (~mag + 32'd1) : mag;
    endfunction

    // Two's complement Q2.frac_w (sign-extended to 32 bits) -> float32.
    // Leading-one priority encoder, mantissa truncated, zero gives +0.0.
    function automatic float32_t fix_to_f32(input logic [31:0] v, input int frac_w);
        float32_t    r;
        logic [31:0] mag;
        logic [4:0]  lead;
        r    = '0;
        mag  = v[31] ? (~v + 32'd1) : v;
        lead = 5'd0;
        for (int k = 0; k < 32; k++) begin
            if (mag[k]) begin
                lead = 5'(k);
            end
        end
        if (mag != 32'd0) begin
            r.sign = v[31];
            r.exp  = 8'(127 + int'(lead) - frac_w);
            r.mant = 23'((mag << (5'd31 - lead)) >> 8);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_iter.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_iter
//  Description : One combinational CORDIC micro-rotation (rotation mode).
//                d = sign of z; x -= d*(y>>>SHIFT); y += d*(x>>>SHIFT);
//                z -= d*atan(2^-SHIFT).
//  Ports       : i_x/i_y/i_z  current vector and residual angle, Q2.(DATA_W-2)
//                o_x/o_y/o_z  rotated vector and updated residual angle
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_iter
    import cordic_pkg::*;
#(
    parameter int DATA_W = 22,
    parameter int SHIFT  = 0
) (
    input  logic signed [DATA_W-1:0] i_x,
    input  logic signed [DATA_W-1:0] i_y,
    input  logic signed [DATA_W-1:0] i_z,
    output logic signed [DATA_W-1:0] o_x,
    output logic signed [DATA_W-1:0] o_y,
    output logic signed [DATA_W-1:0] o_z
);

    localparam logic signed [DATA_W-1:0] c_ATAN = ATAN_TABLE[SHIFT][31 -: DATA_W];

    logic signed [DATA_W-1:0] w_xs;
    logic signed [DATA_W-1:0] w_ys;
    logic                     w_dpos;

    assign w_xs   = i_x >>> SHIFT;
    assign w_ys   = i_y >>> SHIFT;
    assign w_dpos = ~i_z[DATA_W-1];

    assign o_x = w_dpos ? (i_x - w_ys)   : (i_x + w_ys);
    assign o_y = w_dpos ? (i_y + w_xs)   : (i_y - w_xs);
    assign o_z = w_dpos ? (i_z - c_ATAN) : (i_z + c_ATAN);

endmodule
`default_nettype wire

// File: rtl/cordic_cos_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_cos_pipe
//  Description : Streaming float32 CORDIC cosine with valid/ready handshake,
//                full-pipeline stall, sideband tag and range flag.
//                Latency 2 + NUM_STAGES/REG_EVERY cycles.
//  Ports       : clk, reset (sync, active high)
//                in_valid/in_ready/float_in/tag_in      input stream
//                out_valid/out_ready/float_out/tag_out  output stream
//                range_err  input was clamped (|x|>1.0, Inf, NaN)
//                sin_out    float32 of final y (only with CORDIC_SINE_OUT_EN)
//  Config      : `define CORDIC_SINE_OUT_EN adds the sin_out port.
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_cos_pipe
    import cordic_pkg::*;
#(
    parameter int NUM_STAGES = 16,
    parameter int DATA_W     = 22,
    parameter int REG_EVERY  = 1,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      float_in,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      float_out,
    output logic [TAG_W-1:0] tag_out,
`ifdef CORDIC_SINE_OUT_EN
    output logic [31:0]      sin_out,
`endif
    output logic             range_err
);

    localparam int c_NREG = NUM_STAGES / REG_EVERY;

    // K rounded to nearest at DATA_W bits.
    localparam logic [63:0]              c_K_HALF = (64'd1 << (32 - DATA_W)) >> 1;
    localparam logic [31:0]              c_K_RND  = 32'(64'(CORDIC_K) + c_K_HALF);
    localparam logic signed [DATA_W-1:0] c_K      = c_K_RND[31 -: DATA_W];

    // Single enable: the whole pipe advances only when the output slot frees.
    logic w_en;
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    // Register stage 0 holds the converted angle; stage s (1..c_NREG) holds
    // the result after s*REG_EVERY micro-rotations.
    logic signed [DATA_W-1:0] r_x   [0:c_NREG];
    logic signed [DATA_W-1:0] r_y   [0:c_NREG];
    logic signed [DATA_W-1:0] r_z   [0:c_NREG];
    logic                     r_v   [0:c_NREG];
    logic [TAG_W-1:0]         r_tag [0:c_NREG];
    logic                     r_err [0:c_NREG];

    logic signed [DATA_W-1:0] w_xi [0:NUM_STAGES-1];
    logic signed [DATA_W-1:0] w_yi [0:NUM_STAGES-1];
    logic signed [DATA_W-1:0] w_zi [0:NUM_STAGES-1];
    logic signed [DATA_W-1:0] w_xo [0:NUM_STAGES-1];
    logic signed [DATA_W-1:0] w_yo [0:NUM_STAGES-1];
    logic signed [DATA_W-1:0] w_zo [0:NUM_STAGES-1];

    generate
        for (genvar g = 0; g < NUM_STAGES; g++) begin : g_iter
            if ((g % REG_EVERY) == 0) begin : g_from_reg
                assign w_xi[g] = r_x[g / REG_EVERY];
                assign w_yi[g] = r_y[g / REG_EVERY];
                assign w_zi[g] = r_z[g / REG_EVERY];
            end else begin : g_from_comb
                assign w_xi[g] = w_xo[g-1];
                assign w_yi[g] = w_yo[g-1];
                assign w_zi[g] = w_zo[g-1];
            end

            cordic_iter #(
                .DATA_W (DATA_W),
                .SHIFT  (g)
            ) u_iter (
                .i_x (w_xi[g]),
                .i_y (w_yi[g]),
                .i_z (w_zi[g]),
                .o_x (w_xo[g]),
                .o_y (w_yo[g]),
                .o_z (w_zo[g])
            );
        end
    endgenerate

    // Valid bits: the only pipeline state that needs clearing on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s <= c_NREG; s++) begin
                r_v[s] <= 1'b0;
            end
        end else if (w_en) begin
            r_v[0] <= in_valid;
            for (int s = 1; s <= c_NREG; s++) begin
                r_v[s] <= r_v[s-1];
            end
        end
    end

    // Datapath registers; contents behind a clear valid bit are don't-care.
    always_ff @(posedge clk) begin
        if (w_en) begin
            r_x[0]   <= c_K;
            r_y[0]   <= '0;
            r_z[0]   <= DATA_W'(f32_to_fix(float_in, DATA_W - 2));
            r_tag[0] <= tag_in;
            r_err[0] <= f32_out_of_range(float_in);
            for (int s = 1; s <= c_NREG; s++) begin
                r_x[s]   <= w_xo[s*REG_EVERY - 1];
                r_y[s]   <= w_yo[s*REG_EVERY - 1];
                r_z[s]   <= w_zo[s*REG_EVERY - 1];
                r_tag[s] <= r_tag[s-1];
                r_err[s] <= r_err[s-1];
            end
        end
    end

    // Output stage: fixed -> float.
    logic             r_ovalid;
    logic [31:0]      r_fout;
    logic [TAG_W-1:0] r_tagout;
    logic             r_rerr;
`ifdef CORDIC_SINE_OUT_EN
    logic [31:0]      r_sin;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovalid <= 1'b0;
            r_fout   <= '0;
            r_tagout <= '0;
            r_rerr   <= 1'b0;
`ifdef CORDIC_SINE_OUT_EN
            r_sin    <= '0;
`endif
        end else if (w_en) begin
            r_ovalid <= r_v[c_NREG];
            r_fout   <= fix_to_f32(32'(r_x[c_NREG]), DATA_W - 2);
            r_tagout <= r_tag[c_NREG];
            r_rerr   <= r_err[c_NREG];
`ifdef CORDIC_SINE_OUT_EN
            r_sin    <= fix_to_f32(32'(r_y[c_NREG]), DATA_W - 2);
`endif
        end
    end

    assign out_valid = r_ovalid;
    assign float_out = r_fout;
    assign tag_out   = r_tagout;
    assign range_err = r_rerr;
`ifdef CORDIC_SINE_OUT_EN
    assign sin_out   = r_sin;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cordic_cos_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_cos_pipe
//  Description : Scoreboard bench for cordic_cos_pipe. Expected results come
//                from real-valued $cos/$sin of the decoded, clamped input.
//                With CORDIC_SINE_OUT_EN defined the bench uses the wide
//                configuration (24 stages, 32 bits, register every 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_cos_pipe;

`ifdef CORDIC_SINE_OUT_EN
    localparam int NS = 24;
    localparam int DW = 32;
    localparam int RE = 4;
`else
    localparam int NS = 16;
    localparam int DW = 22;
    localparam int RE = 1;
`endif
    localparam int TW   = 4;
    localparam int L    = 2 + NS / RE;
    localparam int MINB = (NS < DW - 4) ? NS : DW - 4;
    // Accuracy bound 2^-min(NS,DW-4), widened 4x to cover the residual angle
    // of the last micro-rotation plus fixed-point truncation.
    localparam real TOL = 4.0 * (2.0 ** (-MINB));

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   float_in;
    logic [TW-1:0] tag_in;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   float_out;
    logic [TW-1:0] tag_out;
    logic          range_err;
`ifdef CORDIC_SINE_OUT_EN
    logic [31:0]   sin_out;
`endif

    cordic_cos_pipe #(
        .NUM_STAGES (NS),
        .DATA_W     (DW),
        .REG_EVERY  (RE),
        .TAG_W      (TW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .float_in  (float_in),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .float_out (float_out),
        .tag_out   (tag_out),
`ifdef CORDIC_SINE_OUT_EN
        .sin_out   (sin_out),
`endif
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] tag;
        bit            err;
        real           c;
        real           s;
        bit            lat;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   stall_lo = -1;
    int   stall_hi = -1;
    bit   rand_rdy = 1'b0;

    task automatic chk(input bit ok, input string name, input string msg);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: %s", name, msg);
        end
    endtask

    function automatic real absr(input real a);
        return (a < 0.0) ? -a : a;
    endfunction

    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        e = int'(b[30:23]);
        if (e == 0) return 0.0;
        m = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** real'(e - 127));
        return b[31] ? -m : m;
    endfunction

    // Reference: decode angle, clamp out-of-range/Inf/NaN, take cos/sin.
    function automatic void model(input logic [31:0] f, output real c, output real s,
                                  output bit err);
        real a;
        int  e;
        e   = int'(f[30:23]);
        err = 1'b0;
        if (e == 255) begin
            err = 1'b1;
            a   = (f[22:0] != 0) ? 1.0 : (f[31] ? -1.0 : 1.0);
        end else if (e == 0) begin
            a = 0.0;
        end else begin
            a = f2r(f);
            if (a > 1.0 || a < -1.0) begin
                err = 1'b1;
                a   = (a > 0.0) ? 1.0 : -1.0;
            end
        end
        c = $cos(a);
        s = $sin(a);
    endfunction

    function automatic logic [31:0] rnd_float();
        logic [7:0] e;
        int         sel;
        sel = $urandom_range(0, 15);
        case (sel)
            0:       e = 8'd0;
            1:       e = 8'd255;
            2:       e = 8'd128;
            3:       e = 8'd127;
            default: e = 8'($urandom_range(100, 126));
        endcase
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    function automatic logic [31:0] rnd_in_range();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 126)), 23'($urandom)};
    endfunction

    // Cycle counter and output-ready driver.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = !(cyc >= stall_lo && cyc < stall_hi) &&
                        (!rand_rdy || ($urandom_range(0, 3) != 0));
        end
    end

    // Offer one item until accepted; push the expectation on acceptance.
    task automatic send(input logic [31:0] f, input logic [TW-1:0] t, input bit lat);
        int   guard;
        bit   done;
        exp_t e;
        guard    = 0;
        done     = 1'b0;
        in_valid = 1'b1;
        float_in = f;
        tag_in   = t;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                model(f, e.c, e.s, e.err);
                e.tag = t;
                e.lat = lat;
                e.cyc = cyc;
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            guard++;
            if (!done && guard > 1000) begin
                chk(1'b0, "accept_timeout", $sformatf("in_ready stayed low, item %h", f));
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(sb.size() == 0, "drain", $sformatf("%0d results outstanding, required 0", sb.size()));
    endtask

    // Monitor: compares each transferred output, checks hold while stalled.
    initial begin
        bit            stalled_prev;
        logic [31:0]   h_f;
        logic [TW-1:0] h_t;
        logic          h_e;
`ifdef CORDIC_SINE_OUT_EN
        logic [31:0]   h_s;
`endif
        exp_t          e;
        real           got;
        stalled_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && out_valid) begin
                if (stalled_prev) begin
                    chk(float_out == h_f && tag_out == h_t && range_err == h_e, "hold",
                        $sformatf("out %h/%0d/%0d, held %h/%0d/%0d",
                                  float_out, tag_out, range_err, h_f, h_t, h_e));
`ifdef CORDIC_SINE_OUT_EN
                    chk(sin_out == h_s, "hold_sin", $sformatf("got %h, held %h", sin_out, h_s));
`endif
                end
                if (!out_ready) begin
                    chk(in_ready == 1'b0, "in_ready_stall", $sformatf("got %0d, required 0", in_ready));
                    h_f = float_out;
                    h_t = tag_out;
                    h_e = range_err;
`ifdef CORDIC_SINE_OUT_EN
                    h_s = sin_out;
`endif
                    stalled_prev = 1'b1;
                end else begin
                    stalled_prev = 1'b0;
                    if (sb.size() == 0) begin
                        chk(1'b0, "unexpected_output", $sformatf("tag %0d appeared, none expected", tag_out));
                    end else begin
                        e   = sb.pop_front();
                        got = f2r(float_out);
                        chk(tag_out == e.tag, "tag", $sformatf("got %0d, required %0d", tag_out, e.tag));
                        chk(range_err == e.err, "range_err",
                            $sformatf("tag %0d got %0d, required %0d", e.tag, range_err, e.err));
                        chk(absr(got - e.c) <= TOL, "cos",
                            $sformatf("tag %0d got %f (%h), required %f", e.tag, got, float_out, e.c));
`ifdef CORDIC_SINE_OUT_EN
                        chk(absr(f2r(sin_out) - e.s) <= TOL, "sin",
                            $sformatf("tag %0d got %f (%h), required %f", e.tag, f2r(sin_out), sin_out, e.s));
`endif
                        if (e.lat) begin
                            chk(cyc - e.cyc == L, "latency",
                                $sformatf("got %0d cycles, required %0d", cyc - e.cyc, L));
                        end
                    end
                end
            end else begin
                stalled_prev = 1'b0;
            end
        end
    end

    logic [31:0] dir_f [10] = '{32'h3F40_0000, 32'h0000_0000, 32'h3F80_0000, 32'hBF40_0000,
                               32'h4000_0000, 32'h7FC0_0000, 32'h7F80_0000, 32'hFF80_0000,
                               32'h0000_0001, 32'hBF80_0000};

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        float_in = '0;
        tag_in   = '0;

        // Reset state.
        @(posedge clk);
        @(negedge clk);
        chk(out_valid == 1'b0 && float_out == 32'd0 && tag_out == '0 && range_err == 1'b0,
            "reset_state", $sformatf("got v=%0d f=%h t=%0d e=%0d, required all 0",
                                     out_valid, float_out, tag_out, range_err));
`ifdef CORDIC_SINE_OUT_EN
        chk(sin_out == 32'd0, "reset_sin", $sformatf("got %h, required 0", sin_out));
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        // Directed values, one at a time so latency is exact.
        for (int i = 0; i < 10; i++) begin
            send(dir_f[i], (i == 0) ? TW'(3) : TW'(i), 1'b1);
            wait_drain(L + 20);
        end

        // 20 back-to-back items with a 5-cycle output stall mid-stream.
        stall_lo = cyc + L + 6;
        stall_hi = stall_lo + 5;
        for (int i = 0; i < 20; i++) begin
            send(rnd_in_range(), TW'(i), 1'b0);
        end
        wait_drain(L + 60);
        stall_lo = -1;
        stall_hi = -1;

        // Reset with 10 items in flight: all of them must vanish.
        for (int i = 0; i < 10; i++) begin
            send(rnd_in_range(), TW'(10 + i), 1'b0);
        end
        reset = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk(out_valid == 1'b0, "post_reset_valid", $sformatf("got %0d, required 0", out_valid));
        repeat (L + 5) begin
            @(posedge clk);
            #1;
        end
        send(32'h3F00_0000, TW'(5), 1'b1);
        wait_drain(L + 20);

        // Randomised traffic with input gaps and random backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send(rnd_float(), TW'($urandom), 1'b0);
        end
        wait_drain(L + 400);
        rand_rdy = 1'b0;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
